// File: rtl/fishingrod_pkg.sv
// Shared types and phase lookup tables for the Fishingrod sequencer.
// Optional FISHINGROD_CTRL_EARLY_TERM_EN builds use clamp_rounds().
package fishingrod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int         PHASES     = 12;
  localparam logic [3:0] LAST_PHASE = 4'(PHASES - 1);

  // Vectors are [0:4]; the leftmost literal bit is index 0.
  localparam logic [0:4] SELS_TAB [PHASES] = '{
    5'b00000, 5'b00000, 5'b00000, 5'b01000,
    5'b00100, 5'b00010, 5'b10000, 5'b10000,
    5'b00000, 5'b00000, 5'b00000, 5'b00000
  };

  // selk[2] (round constant) depends on state and is added by the decoder.
  localparam logic [0:4] SELK_TAB [PHASES] = '{
    5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b01000, 5'b01000, 5'b10000, 5'b10000,
    5'b11000, 5'b11000, 5'b11000, 5'b11010
  };

  function automatic logic [4:0] clamp_rounds(input logic [4:0] req,
                                              input logic [4:0] max_rounds);
    if (req == 5'd0)       return 5'd1;
    if (req > max_rounds)  return max_rounds;
    return req;
  endfunction

endpackage

// File: rtl/fishingrod_ctrl_if.sv
// Host/datapath control bundle for fishingrod_ctrl (nrounds_i present only
// when FISHINGROD_CTRL_EARLY_TERM_EN is defined).
interface fishingrod_ctrl_if;
  import fishingrod_pkg::*;

  // Strobes carry no backpressure: in_ready means the datapath consumes one
  // plaintext and one key byte this cycle, out_valid means one ciphertext
  // byte is on the datapath output this cycle; the host must keep up.
  logic       start;
`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
  logic [4:0] nrounds_i;
`endif
  logic       busy;
  logic       in_ready;
  logic       out_valid;
  logic       done;
  logic       round0;
  logic [0:4] round;
  logic [0:4] sels;
  logic [0:4] selk;
  state_t     state;
  logic [3:0] phase;

  modport master (
`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
    output nrounds_i,
`endif
    output start,
    input  busy, in_ready, out_valid, done, round0, round, sels, selk,
    input  state, phase
  );

  modport slave (
`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
    input  nrounds_i,
`endif
    input  start,
    output busy, in_ready, out_valid, done, round0, round, sels, selk,
    output state, phase
  );

endinterface

// File: rtl/fishingrod_phase_dec.sv
// Combinational decode of (state, phase) into the datapath mux selects.
module fishingrod_phase_dec
  import fishingrod_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] phase,
  output logic [0:4] sels,
  output logic [0:4] selk
);

  always_comb begin
    sels = '0;
    selk = '0;
    if (state != IDLE && phase <= LAST_PHASE) begin
      sels    = SELS_TAB[phase];
      selk    = SELK_TAB[phase];
      selk[2] = (state == RUN) && (phase == 4'd0);
    end
  end

endmodule

// File: rtl/fishingrod_ctrl.sv
// Fishingrod sequencer: 12-cycle load, NROUNDS x 12-cycle rounds, done pulse.
// Define FISHINGROD_CTRL_EARLY_TERM_EN for a per-run round count (nrounds_i).
module fishingrod_ctrl
  import fishingrod_pkg::*;
#(
  parameter int NROUNDS = 20
) (
  input  logic              ck,
  input  logic              rst,
  fishingrod_ctrl_if.slave  bus
);

  state_t     state;
  logic [3:0] phase;
  logic [4:0] round_q;
  logic       done_q;
  logic [4:0] nr_lim;

`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
  logic [4:0] nr_q;
  assign nr_lim = nr_q;
`else
  assign nr_lim = 5'(NROUNDS);
`endif

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 4'd0;
      round_q <= 5'd0;
      done_q  <= 1'b0;
`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
      nr_q    <= 5'(NROUNDS);
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          phase   <= 4'd0;
          round_q <= 5'd0;
          if (bus.start) begin
            state <= LOAD;
`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
            nr_q  <= clamp_rounds(bus.nrounds_i, 5'(NROUNDS));
`endif
          end
        end
        LOAD: begin
          if (phase == LAST_PHASE) begin
            state   <= RUN;
            phase   <= 4'd0;
            round_q <= 5'd1;
          end else begin
            phase <= phase + 4'd1;
          end
        end
        RUN: begin
          if (phase == LAST_PHASE) begin
            phase <= 4'd0;
            if (round_q < nr_lim) begin
              round_q <= round_q + 5'd1;
            end else begin
              // done lands in the first IDLE cycle, so start there is accepted
              state   <= IDLE;
              round_q <= 5'd0;
              done_q  <= 1'b1;
            end
          end else begin
            phase <= phase + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          phase   <= 4'd0;
          round_q <= 5'd0;
        end
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = (state == LOAD);
  assign bus.round0    = (state == LOAD);
  assign bus.round     = round_q;
  assign bus.out_valid = (state == RUN) && (round_q == nr_lim);
  assign bus.done      = done_q;
  assign bus.state     = state;
  assign bus.phase     = phase;

  fishingrod_phase_dec u_dec (
    .state (state),
    .phase (phase),
    .sels  (bus.sels),
    .selk  (bus.selk)
  );

endmodule

// File: tb/tb_fishingrod_ctrl.sv
// Directed bench for fishingrod_ctrl: reset, full runs, phase tables,
// ignored/coincident start, mid-run reset, optional early termination.
module tb_fishingrod_ctrl;
  import fishingrod_pkg::*;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  fishingrod_ctrl_if bus ();

  fishingrod_ctrl #(.NROUNDS(20)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [19:0] ctl_obs();
    return {bus.busy, bus.in_ready, bus.out_valid, bus.done, bus.round0,
            bus.round, bus.sels, bus.selk};
  endfunction

  function automatic logic [19:0] ctl_exp(bit b, bit ir, bit ov, bit dn,
                                          bit r0, logic [4:0] r,
                                          logic [0:4] s, logic [0:4] k);
    return {b, ir, ov, dn, r0, r, s, k};
  endfunction

  function automatic logic [0:4] e_sels(int ph);
    case (ph)
      3:       return 5'b01000;
      4:       return 5'b00100;
      5:       return 5'b00010;
      6, 7:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [0:4] e_selk(int ph, bit run);
    logic [0:4] v;
    v = 5'b00000;
    if      (ph < 4) v[0:1] = 2'b00;
    else if (ph < 6) v[0:1] = 2'b01;
    else if (ph < 8) v[0:1] = 2'b10;
    else             v[0:1] = 2'b11;
    v[2] = run && (ph == 0);
    v[3] = (ph == 11);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge ck);
      check("idle_ctl", 32'(ctl_obs()), 32'(20'd0));
      check("idle_state", 32'(bus.state), 32'(IDLE));
    end
  endtask

  // One encryption. k counts negedges after the edge that samples start.
  task automatic run_op(input bit pre, input int nr, input int ign_k,
                        input int abort_k, input bit restart);
    int total;
    int lat;
    int dn_cnt;
    int r;
    int ph;
    total = 12 * nr + 13;
    lat   = 0;
    if (abort_k == 0) exp_q.push_back(16'(12 * (nr + 1)));
    if (!pre) bus.start = 1'b1;
    @(negedge ck);
    bus.start = 1'b0;
    for (int k = 1; k <= total; k++) begin
      if (k > 1) @(negedge ck);
      if (k <= 12) begin
        ph = k - 1;
        check("load_ctl", 32'(ctl_obs()),
              32'(ctl_exp(1, 1, 0, 0, 1, 5'd0, e_sels(ph), e_selk(ph, 0))));
        check("load_state", 32'(bus.state), 32'(LOAD));
        check("load_phase", 32'(bus.phase), 32'(ph));
      end else if (k < total) begin
        r  = (k - 13) / 12 + 1;
        ph = (k - 13) % 12;
        check("run_ctl", 32'(ctl_obs()),
              32'(ctl_exp(1, 0, (r == nr), 0, 0, 5'(r), e_sels(ph),
                          e_selk(ph, 1))));
        check("run_state", 32'(bus.state), 32'(RUN));
        check("run_phase", 32'(bus.phase), 32'(ph));
      end else begin
        check("done_ctl", 32'(ctl_obs()),
              32'(ctl_exp(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0)));
        check("done_state", 32'(bus.state), 32'(IDLE));
      end
      if (bus.done === 1'b1 && lat == 0) lat = k - 1;
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1;
        check("rst_ctl", 32'(ctl_obs()), 32'(20'd0));
        check("rst_state", 32'(bus.state), 32'(IDLE));
        check("rst_phase", 32'(bus.phase), 32'd0);
        #1 rst = 1'b0;
        dn_cnt = 0;
        repeat (260) begin
          @(negedge ck);
          if (bus.done === 1'b1) dn_cnt++;
        end
        check("rst_no_done", 32'(dn_cnt), 32'd0);
        check("rst_idle_ctl", 32'(ctl_obs()), 32'(20'd0));
        return;
      end
      bus.start = (k == ign_k) || (restart && k == total);
    end
    check("latency", 32'(lat), 32'(exp_q.pop_front()));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
    bus.nrounds_i = 5'd20;
`endif
    repeat (2) @(negedge ck);
    check("reset_ctl", 32'(ctl_obs()), 32'(20'd0));
    check("reset_state", 32'(bus.state), 32'(IDLE));
    check("reset_phase", 32'(bus.phase), 32'd0);
    rst = 1'b0;
    idle_cycles(5);

    // full run; start in round 5 phase 7 is ignored; restart on done
    run_op(0, 20, 68, 0, 1);
    // back-to-back run, reset at round 10 phase 4
    run_op(1, 20, 0, 125, 0);
    idle_cycles($urandom_range(1, 4));
    run_op(0, 20, 0, 0, 0);
    idle_cycles($urandom_range(1, 4));

`ifdef FISHINGROD_CTRL_EARLY_TERM_EN
    bus.nrounds_i = 5'd3;
    run_op(0, 3, 0, 0, 0);
    idle_cycles($urandom_range(1, 4));
    bus.nrounds_i = 5'd0;
    run_op(0, 1, 0, 0, 0);
    idle_cycles($urandom_range(1, 4));
    bus.nrounds_i = 5'd31;
    run_op(0, 20, 0, 0, 0);
    idle_cycles(2);
`endif

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
